// File: rtl/cpu64_l1i_refill.sv
// cpu64_l1i_refill: L1I miss-refill engine; invalidates the victim, fetches 8 beats, installs tag and updates PLRU.
// Define CPU64_L1I_REFILL_CWF_EN for critical-word-first beat ordering.
module cpu64_l1i_refill #(
  parameter int ADDR_W = 64,
  parameter int BEAT_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              miss_valid_i,
  output logic              miss_ready_o,
  input  logic [ADDR_W-1:0] miss_addr_i,
  input  logic              kill_i,
  output logic [5:0]        set_o,
  input  logic [2:0]        victim_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [BEAT_W-1:0] mem_rsp_data_i,
  input  logic              mem_rsp_err_i,
  output logic              data_we_o,
  output logic [5:0]        data_set_o,
  output logic [2:0]        data_way_o,
  output logic [2:0]        data_word_o,
  output logic [BEAT_W-1:0] data_wdata_o,
  output logic              tag_we_o,
  output logic [5:0]        tag_set_o,
  output logic [2:0]        tag_way_o,
  output logic [ADDR_W-13:0] tag_wdata_o,
  output logic              tag_valid_o,
  output logic              plru_access_o,
  output logic [2:0]        plru_way_o,
  output logic              done_o,
  output logic              err_o
);
  typedef enum logic [2:0] {IDLE, INVAL, REQ, RESP, COMMIT} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0] r_way, r_beat;
  logic r_err, r_kill;
  logic w_beat, w_idle, w_commit_ok, w_unused;
  assign w_idle = r_state == IDLE;
  assign w_beat = (r_state == RESP) && mem_rsp_valid_i;
  assign w_commit_ok = (r_state == COMMIT) && !r_err;
  assign w_unused = ^r_addr[5:0];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_way   <= '0;
      r_beat  <= '0;
      r_err   <= 1'b0;
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_idle) begin
        if (miss_valid_i) begin
          r_addr <= miss_addr_i;
          r_way  <= victim_i;
          r_beat <= '0;
          r_err  <= 1'b0;
          r_kill <= 1'b0;
        end
      end else begin
        if (kill_i) r_kill <= 1'b1;
        if (w_beat) begin
          r_beat <= r_beat + 3'd1;
          if (mem_rsp_err_i) r_err <= 1'b1;
        end
      end
    end
  end
  // the 3-bit beat counter wrapping past word 7 ends the burst
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = miss_valid_i ? INVAL : IDLE;
      INVAL:   w_next = REQ;
      REQ:     w_next = mem_req_ready_i ? RESP : REQ;
      RESP:    w_next = (w_beat && r_beat == 3'd7) ? COMMIT : RESP;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  assign miss_ready_o    = w_idle;
  assign set_o           = w_idle ? miss_addr_i[11:6] : r_addr[11:6];
  assign mem_req_valid_o = r_state == REQ;
`ifdef CPU64_L1I_REFILL_CWF_EN
  assign mem_req_addr_o  = {r_addr[ADDR_W-1:3], 3'b0};
  assign data_word_o     = r_beat + r_addr[5:3];
`else
  assign mem_req_addr_o  = {r_addr[ADDR_W-1:6], 6'b0};
  assign data_word_o     = r_beat;
`endif
  assign data_we_o       = w_beat && !r_err && !mem_rsp_err_i;
  assign data_set_o      = r_addr[11:6];
  assign data_way_o      = r_way;
  assign data_wdata_o    = w_beat ? mem_rsp_data_i : '0;
  assign tag_we_o        = (r_state == INVAL) || w_commit_ok;
  assign tag_set_o       = r_addr[11:6];
  assign tag_way_o       = r_way;
  assign tag_wdata_o     = r_addr[ADDR_W-1:12];
  assign tag_valid_o     = w_commit_ok;
  assign plru_access_o   = w_commit_ok;
  assign plru_way_o      = r_way;
  assign done_o          = w_commit_ok && !r_kill && !kill_i;
  assign err_o           = (r_state == COMMIT) && r_err;
endmodule

// File: tb/tb_cpu64_l1i_refill.sv
// tb_cpu64_l1i_refill: directed scoreboard bench for the L1I refill engine.
module tb_cpu64_l1i_refill;
  logic clk = 1'b0, rst_ni = 1'b0;
  logic miss_valid = 1'b0, kill = 1'b0, req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
  logic [63:0] miss_addr = '0, rsp_data = '0;
  logic [2:0] victim = '0;
  logic miss_ready_o, mem_req_valid_o, data_we_o, tag_we_o, tag_valid_o, plru_access_o, done_o, err_o;
  logic [5:0] set_o, data_set_o, tag_set_o;
  logic [2:0] data_way_o, data_word_o, tag_way_o, plru_way_o;
  logic [63:0] mem_req_addr_o, data_wdata_o;
  logic [51:0] tag_wdata_o;
  int checks = 0, errors = 0;

  typedef struct {logic [5:0] set; logic [2:0] way; logic [2:0] word; logic [63:0] data;} dexp_t;
  typedef struct {logic [5:0] set; logic [2:0] way; logic [51:0] tag; logic valid;} texp_t;
  typedef struct {logic plru; logic [2:0] way; logic done; logic err;} cexp_t;
  dexp_t dq[$];
  texp_t tq[$];
  cexp_t cq[$];
  dexp_t md;
  texp_t mt;
  cexp_t mc;

  cpu64_l1i_refill dut (
    .clk_i(clk), .rst_ni(rst_ni), .miss_valid_i(miss_valid), .miss_ready_o(miss_ready_o),
    .miss_addr_i(miss_addr), .kill_i(kill), .set_o(set_o), .victim_i(victim),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(req_ready), .mem_req_addr_o(mem_req_addr_o),
    .mem_rsp_valid_i(rsp_valid), .mem_rsp_data_i(rsp_data), .mem_rsp_err_i(rsp_err),
    .data_we_o(data_we_o), .data_set_o(data_set_o), .data_way_o(data_way_o),
    .data_word_o(data_word_o), .data_wdata_o(data_wdata_o), .tag_we_o(tag_we_o),
    .tag_set_o(tag_set_o), .tag_way_o(tag_way_o), .tag_wdata_o(tag_wdata_o),
    .tag_valid_o(tag_valid_o), .plru_access_o(plru_access_o), .plru_way_o(plru_way_o),
    .done_o(done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, miss_ready_o, 1);
    chk({tag, "_zero"}, {mem_req_valid_o, mem_req_addr_o, data_we_o, data_set_o, data_way_o,
        data_word_o, data_wdata_o, tag_we_o, tag_set_o, tag_way_o, tag_wdata_o, tag_valid_o,
        plru_access_o, plru_way_o, done_o, err_o, set_o} == '0, 1);
  endtask

  always @(negedge clk) begin
    if (data_we_o) begin
      if (dq.size() == 0) chk("data_spurious", 1, 0);
      else begin
        md = dq.pop_front();
        chk("data_set", data_set_o, md.set);
        chk("data_way", data_way_o, md.way);
        chk("data_word", data_word_o, md.word);
        chk("data_wdata", data_wdata_o, md.data);
      end
    end
    if (tag_we_o) begin
      if (tq.size() == 0) chk("tag_spurious", 1, 0);
      else begin
        mt = tq.pop_front();
        chk("tag_set", tag_set_o, mt.set);
        chk("tag_way", tag_way_o, mt.way);
        chk("tag_valid", tag_valid_o, mt.valid);
        if (mt.valid) chk("tag_wdata", tag_wdata_o, mt.tag);
      end
    end
    if (plru_access_o || done_o || err_o) begin
      if (cq.size() == 0) chk("commit_spurious", 1, 0);
      else begin
        mc = cq.pop_front();
        chk("commit_flags", {plru_access_o, done_o, err_o}, {mc.plru, mc.done, mc.err});
        if (mc.plru) chk("plru_way", plru_way_o, mc.way);
      end
    end
  end

  // eb: error beat, kb: kill beat (8 = COMMIT cycle), rb: reset after this beat; -1/8 disable
  task automatic do_miss(input logic [63:0] a, input logic [2:0] v, input int dly,
                         input int eb, input int kb, input int rb);
    logic [63:0] d, ea;
    logic [2:0] w;
    logic [5:0] s;
    logic e;
    e = 1'b0;
    s = a[11:6];
`ifdef CPU64_L1I_REFILL_CWF_EN
    ea = {a[63:3], 3'b0};
`else
    ea = {a[63:6], 6'b0};
`endif
    miss_valid = 1'b1; miss_addr = a; victim = v;
    @(negedge clk);
    chk("miss_ready", miss_ready_o, 1);
    chk("set_idle", set_o, s);
    tq.push_back('{s, v, 52'd0, 1'b0});
    step();
    miss_valid = 1'b0; miss_addr = '0; victim = '0;
    @(negedge clk);
    chk("busy", miss_ready_o, 0);
    chk("set_busy", set_o, s);
    step();
    req_ready = 1'b0;
    repeat (dly) begin
      @(negedge clk);
      chk("req_valid_wait", mem_req_valid_o, 1);
      chk("req_addr_wait", mem_req_addr_o, ea);
      step();
    end
    req_ready = 1'b1;
    @(negedge clk);
    chk("req_valid", mem_req_valid_o, 1);
    chk("req_addr", mem_req_addr_o, ea);
    step();
    req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == rb + 1) begin
        rsp_valid = 1'b1; rsp_data = {$urandom, $urandom}; rsp_err = 1'b0; rst_ni = 1'b0;
        @(negedge clk);
        chk_reset("mid_reset");
        step();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("late_beat_dropped", data_we_o, 0);
        chk("ready_after_reset", miss_ready_o, 1);
        step();
        rsp_valid = 1'b0;
        return;
      end
      d = {$urandom, $urandom};
`ifdef CPU64_L1I_REFILL_CWF_EN
      w = a[5:3] + 3'(i);
`else
      w = 3'(i);
`endif
      rsp_valid = 1'b1; rsp_data = d; rsp_err = (i == eb); kill = (i == kb);
      if (i == eb) e = 1'b1;
      if (!e) dq.push_back('{s, v, w, d});
      if (i == 0) begin
        @(negedge clk);
        chk("one_handshake", mem_req_valid_o, 0);
      end
      step();
    end
    rsp_valid = 1'b0; rsp_err = 1'b0; kill = (kb == 8);
    if (e) cq.push_back('{1'b0, 3'd0, 1'b0, 1'b1});
    else begin
      tq.push_back('{s, v, a[63:12], 1'b1});
      cq.push_back('{1'b1, v, kb < 0, 1'b0});
    end
    @(negedge clk);
    chk("commit_busy", miss_ready_o, 0);
    chk("commit_done", done_o, !e && kb < 0);
    chk("commit_err", err_o, e);
    step();
    kill = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    chk_reset("reset");
    step();
    rst_ni = 1'b1;
    kill = 1'b1;
    step();
    kill = 1'b0;
    do_miss(64'h1_2340, 3'd5, 0, -1, -1, 8);
    do_miss(64'h1_2358, 3'd2, 0, -1, -1, 8);
    do_miss(64'hABCD_E0C8, 3'd1, 4, -1, -1, 8);
    do_miss(64'h0F00_0F40, 3'd3, 1, 2, -1, 8);
    do_miss(64'h5555_5A80, 3'd6, 0, -1, 3, 8);
    do_miss(64'h7777_7FF8, 3'd7, 0, -1, -1, 8);
    do_miss(64'h2468_ACC0, 3'd4, 2, -1, 8, 8);
    do_miss(64'h1357_9B00, 3'd0, 0, -1, -1, 4);
    do_miss(64'h9ABC_1238, 3'd5, 1, -1, -1, 8);
    @(negedge clk);
    chk("final_ready", miss_ready_o, 1);
    chk("dq_empty", dq.size(), 0);
    chk("tq_empty", tq.size(), 0);
    chk("cq_empty", cq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
